// File: rtl/ipg_pkg.sv
// IPG side-channel shared definitions.
// Block-type codes, error codes, receiver state encoding.
package ipg_pkg;

  localparam logic [7:0] T_RD_FIRST = 8'h09;
  localparam logic [7:0] T_RD_MID   = 8'h19;
  localparam logic [7:0] T_RD_LAST  = 8'h29;

  localparam logic [7:0] T_RR_FIRST = 8'h0b;
  localparam logic [7:0] T_RR_MID   = 8'h1b;
  localparam logic [7:0] T_RR_LAST  = 8'h2b;

  localparam logic [7:0] T_WR_FIRST = 8'h0a;
  localparam logic [7:0] T_WR_MID   = 8'h1a;
  localparam logic [7:0] T_WR_LAST  = 8'h2a;

  localparam logic [5:0] BLK_LEN = 6'd56;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_TYPE    = 3'd1,
    ERR_RESTART = 3'd2,
    ERR_TIMEOUT = 3'd3,
    ERR_LEN     = 3'd4,
    ERR_OVF     = 3'd5
  } err_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  // bit i of e flags error code i+1; lowest code wins
  function automatic err_e err_enc(
    input logic [4:0] e
  );
    if (e[0])      return ERR_TYPE;
    else if (e[1]) return ERR_RESTART;
    else if (e[2]) return ERR_TIMEOUT;
    else if (e[3]) return ERR_LEN;
    else if (e[4]) return ERR_OVF;
    else           return ERR_NONE;
  endfunction

endpackage

// File: rtl/ipg_sync_fifo.sv
// Synchronous FIFO, registered storage, full/empty flags.
// Ports: push/din write, pop/dout read, full, empty.
module ipg_sync_fifo #(
  parameter int WIDTH = 57,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  // a pop frees the slot the same cycle
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  // storage is not reset; mask so reset shows zero
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ipg_rresp_rx.sv
// IPG read-response receiver: parses FIRST/MID/LAST blocks
// into a descriptor plus a payload chunk stream, with errors.
// Ports: clk, reset, rx_ipg_data/rx_len/rresp_valid in;
// desc_*, chunk_* (valid/ready), err_valid/err_code, busy.
module ipg_rresp_rx
  import ipg_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 16,
  parameter int ADDR_BLKS  = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_MAX    = 15
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_WIDTH-1:0]             rx_ipg_data,
  input  logic [5:0]                        rx_len,
  input  logic                              rresp_valid,
  output logic                              desc_valid,
  output logic [DATA_WIDTH-9:0]             desc_hdr,
  output logic [ADDR_BLKS*(DATA_WIDTH-8)-1:0] desc_addr,
  output logic [DATA_WIDTH-9:0]             chunk_data,
  output logic                              chunk_last,
  output logic                              chunk_valid,
  input  logic                              chunk_ready,
  output logic                              err_valid,
  output logic [2:0]                        err_code,
  output logic                              busy
);

  localparam int PW = DATA_WIDTH - 8;
  localparam int FW = DATA_WIDTH - 7;
  localparam int AB = ADDR_BLKS * PW;

  state_e               state, state_n;
  logic [PW-1:0]        hdr_q;
  logic [HDR_WIDTH-1:0] exp_cnt;
  logic [HDR_WIDTH-1:0] data_cnt;
  logic [HDR_WIDTH-1:0] gap_cnt;
  logic [2:0]           addr_cnt;
  logic [AB-1:0]        addr_buf;
  logic [AB-1:0]        addr_nxt;

  logic          acc;
  logic [7:0]    typ;
  logic [PW-1:0] payload;
  logic          is_first, is_mid, is_last;
  logic          hit, gap_hit;

  logic          first_ld, addr_wr, desc_fire;
  logic          data_inc, gap_inc;
  logic          push, push_last;
  logic [4:0]    e;

  logic          f_full, f_empty, f_pop;
  logic [FW-1:0] f_dout;

  assign acc      = rresp_valid && (rx_len == BLK_LEN);
  assign typ      = rx_ipg_data[7:0];
  assign payload  = rx_ipg_data[DATA_WIDTH-1:8];
  assign is_first = (typ == T_RR_FIRST);
  assign is_mid   = (typ == T_RR_MID);
  assign is_last  = (typ == T_RR_LAST);
  // widened so a full-scale exp_cnt cannot alias
  assign hit      = ({1'b0, data_cnt} + 1'b1)
                 == {1'b0, exp_cnt};
  assign gap_hit  = (gap_cnt + 1'b1)
                 == HDR_WIDTH'(GAP_MAX);
  assign busy     = (state != S_IDLE);

  always_comb begin
    state_n   = state;
    first_ld  = 1'b0;
    addr_wr   = 1'b0;
    desc_fire = 1'b0;
    data_inc  = 1'b0;
    gap_inc   = 1'b0;
    push      = 1'b0;
    push_last = 1'b0;
    e         = '0;
    unique case (state)
      S_IDLE: begin
        if (acc && is_first) begin
          first_ld = 1'b1;
          state_n  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (!acc) begin
          gap_inc = 1'b1;
        end else if (is_first) begin
          e[1]     = 1'b1;
          first_ld = 1'b1;
        end else if (is_mid) begin
          addr_wr = 1'b1;
          if (addr_cnt == 3'(ADDR_BLKS-1)) begin
            desc_fire = 1'b1;
            state_n   = (exp_cnt == '0) ? S_IDLE
                                        : S_DATA;
          end
        end else begin
          e[0]    = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_DATA: begin
        if (!acc) begin
          gap_inc = 1'b1;
        end else if (is_first) begin
          e[1]     = 1'b1;
          first_ld = 1'b1;
          state_n  = S_ADDR;
        end else if (is_mid || is_last) begin
          push = 1'b1;
          if (is_last || hit) begin
            // early LAST or missing LAST both close
            push_last = 1'b1;
            e[3]      = (is_last != hit);
            state_n   = S_IDLE;
          end else begin
            data_inc = 1'b1;
          end
        end else begin
          e[0]    = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (gap_inc && gap_hit) begin
      e[2]    = 1'b1;
      state_n = S_IDLE;
    end
    e[4] = push && f_full && !f_pop;
  end

  always_comb begin
    addr_nxt = addr_buf;
    for (int i = 0; i < ADDR_BLKS; i++) begin
      if (addr_wr && addr_cnt == 3'(i))
        addr_nxt[(ADDR_BLKS-1-i)*PW +: PW] = payload;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      hdr_q      <= '0;
      exp_cnt    <= '0;
      data_cnt   <= '0;
      gap_cnt    <= '0;
      addr_cnt   <= '0;
      addr_buf   <= '0;
      desc_valid <= 1'b0;
      desc_hdr   <= '0;
      desc_addr  <= '0;
      err_valid  <= 1'b0;
      err_code   <= '0;
    end else begin
      state      <= state_n;
      addr_buf   <= addr_nxt;
      desc_valid <= desc_fire;
      err_valid  <= |e;
      err_code   <= err_enc(e);
      if (first_ld) begin
        hdr_q    <= payload;
        exp_cnt  <= payload[HDR_WIDTH-1:0];
        addr_cnt <= '0;
      end else if (addr_wr) begin
        addr_cnt <= addr_cnt + 1'b1;
      end
      if (desc_fire) begin
        desc_hdr  <= hdr_q;
        desc_addr <= addr_nxt;
        data_cnt  <= '0;
      end else if (data_inc) begin
        data_cnt <= data_cnt + 1'b1;
      end
      if (gap_inc && !gap_hit)
        gap_cnt <= gap_cnt + 1'b1;
      else
        gap_cnt <= '0;
    end
  end

  assign f_pop = chunk_valid && chunk_ready;

  ipg_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({push_last, payload}),
    .pop   (f_pop),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty)
  );

  assign chunk_valid = !f_empty;
  assign chunk_last  = f_dout[FW-1];
  assign chunk_data  = f_dout[PW-1:0];

endmodule

// File: tb/tb_ipg_rresp_rx.sv
// Directed bench for ipg_rresp_rx.
// Default parameters: 64-bit blocks, 2 address blocks.
module tb_ipg_rresp_rx;

  localparam int DW = 64;
  localparam int PW = DW - 8;
  localparam int AB = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] rx_ipg_data;
  logic [5:0]    rx_len;
  logic          rresp_valid;
  logic          desc_valid;
  logic [PW-1:0] desc_hdr;
  logic [AB*PW-1:0] desc_addr;
  logic [PW-1:0] chunk_data;
  logic          chunk_last;
  logic          chunk_valid;
  logic          chunk_ready;
  logic          err_valid;
  logic [2:0]    err_code;
  logic          busy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [PW:0] chunkq [$];
  logic [2:0]  errq [$];
  int          desc_n = 0;

  ipg_rresp_rx dut (
    .clk         (clk),
    .reset       (reset),
    .rx_ipg_data (rx_ipg_data),
    .rx_len      (rx_len),
    .rresp_valid (rresp_valid),
    .desc_valid  (desc_valid),
    .desc_hdr    (desc_hdr),
    .desc_addr   (desc_addr),
    .chunk_data  (chunk_data),
    .chunk_last  (chunk_last),
    .chunk_valid (chunk_valid),
    .chunk_ready (chunk_ready),
    .err_valid   (err_valid),
    .err_code    (err_code),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (desc_valid) desc_n++;
      if (err_valid) errq.push_back(err_code);
      if (chunk_valid && chunk_ready)
        chunkq.push_back({chunk_last, chunk_data});
    end
  end

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic blk(
    input logic [7:0]    t,
    input logic [PW-1:0] p
  );
    rx_ipg_data = {p, t};
    rx_len      = 6'd56;
    rresp_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rresp_valid = 1'b0;
    rx_len      = 6'd0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    chunkq.delete();
    errq.delete();
    desc_n = 0;
  endtask

  initial begin
    reset       = 1'b1;
    rx_ipg_data = '0;
    rx_len      = '0;
    rresp_valid = 1'b0;
    chunk_ready = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    chk("rst_desc_valid", desc_valid, 0);
    chk("rst_chunk_valid", chunk_valid, 0);
    chk("rst_err_valid", err_valid, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_busy", busy, 0);
    chk("rst_chunk_data", chunk_data, 0);

    // 1: nominal message, 3 data blocks
    clr();
    blk(8'h0b, 56'd3);
    chk("t1_busy", busy, 1);
    blk(8'h1b, 56'hA0);
    blk(8'h1b, 56'hA1);
    chk("t1_desc_valid", desc_valid, 1);
    chk("t1_desc_hdr", desc_hdr, 3);
    chk("t1_desc_addr", desc_addr,
        {56'hA0, 56'hA1});
    blk(8'h1b, 56'hD0);
    chk("t1_desc_pulse", desc_valid, 0);
    chk("t1_chunk_lat", chunk_valid, 1);
    blk(8'h1b, 56'hD1);
    blk(8'h2b, 56'hD2);
    chk("t1_busy_end", busy, 0);
    idle(5);
    chk("t1_desc_n", desc_n, 1);
    chk("t1_nchunk", chunkq.size(), 3);
    chk("t1_c0", chunkq[0], {1'b0, 56'hD0});
    chk("t1_c2", chunkq[2], {1'b1, 56'hD2});
    chk("t1_nerr", errq.size(), 0);
    chk("t1_hold_hdr", desc_hdr, 3);

    // 2: LAST arrives early
    clr();
    blk(8'h0b, 56'd3);
    blk(8'h1b, 56'hB0);
    blk(8'h1b, 56'hB1);
    blk(8'h1b, 56'hE0);
    blk(8'h2b, 56'hE1);
    chk("t2_err_valid", err_valid, 1);
    chk("t2_err_code", err_code, 4);
    chk("t2_busy", busy, 0);
    idle(5);
    chk("t2_nchunk", chunkq.size(), 2);
    chk("t2_c1", chunkq[1], {1'b1, 56'hE1});
    chk("t2_nerr", errq.size(), 1);

    // 3: restart during DATA
    clr();
    chunk_ready = 1'b0;
    blk(8'h0b, 56'd3);
    blk(8'h1b, 56'hC0);
    blk(8'h1b, 56'hC1);
    blk(8'h1b, 56'h300);
    blk(8'h1b, 56'h301);
    blk(8'h0b, 56'd1);
    chk("t3_err_code", err_code, 2);
    chk("t3_err_valid", err_valid, 1);
    chk("t3_busy", busy, 1);
    blk(8'h1b, 56'hF0);
    blk(8'h1b, 56'hF1);
    chk("t3_desc_valid", desc_valid, 1);
    chk("t3_desc_hdr", desc_hdr, 1);
    chk("t3_desc_addr", desc_addr,
        {56'hF0, 56'hF1});
    blk(8'h2b, 56'h310);
    chk("t3_busy_end", busy, 0);
    chunk_ready = 1'b1;
    idle(6);
    chk("t3_nchunk", chunkq.size(), 3);
    chk("t3_c0", chunkq[0], {1'b0, 56'h300});
    chk("t3_c1", chunkq[1], {1'b0, 56'h301});
    chk("t3_c2", chunkq[2], {1'b1, 56'h310});
    chk("t3_nerr", errq.size(), 1);
    chk("t3_desc_n", desc_n, 2);

    // 4: FIFO overflow with consumer stalled
    clr();
    chunk_ready = 1'b0;
    blk(8'h0b, 56'd10);
    blk(8'h1b, 56'h11);
    blk(8'h1b, 56'h12);
    for (int i = 0; i < 9; i++)
      blk(8'h1b, 56'h100 + 56'(i));
    blk(8'h2b, 56'h109);
    chk("t4_busy", busy, 0);
    chk("t4_full_valid", chunk_valid, 1);
    idle(1);
    chk("t4_nerr", errq.size(), 2);
    chk("t4_e0", errq[0], 5);
    chk("t4_e1", errq[1], 5);
    chunk_ready = 1'b1;
    idle(12);
    chk("t4_nchunk", chunkq.size(), 8);
    chk("t4_c0", chunkq[0], {1'b0, 56'h100});
    chk("t4_c7", chunkq[7], {1'b0, 56'h107});
    chk("t4_empty", chunk_valid, 0);

    // 5: gap tolerance and timeout
    clr();
    blk(8'h0b, 56'd2);
    blk(8'h1b, 56'h21);
    blk(8'h1b, 56'h22);
    blk(8'h1b, 56'h500);
    idle(14);
    chk("t5_noerr", errq.size(), 0);
    chk("t5_busy_gap", busy, 1);
    blk(8'h2b, 56'h501);
    chk("t5_busy_end", busy, 0);
    idle(3);
    chk("t5_nchunk", chunkq.size(), 2);
    chk("t5_c1", chunkq[1], {1'b1, 56'h501});
    blk(8'h0b, 56'd2);
    blk(8'h1b, 56'h23);
    blk(8'h1b, 56'h24);
    blk(8'h1b, 56'h510);
    idle(14);
    chk("t5_err_early", err_valid, 0);
    idle(1);
    chk("t5_err_valid", err_valid, 1);
    chk("t5_err_code", err_code, 3);
    chk("t5_idle", busy, 0);
    idle(3);
    chk("t5_nerr", errq.size(), 1);

    // 6: zero-length message, then reset mid-DATA
    clr();
    blk(8'h0b, 56'd0);
    blk(8'h1b, 56'h31);
    blk(8'h1b, 56'h32);
    chk("t6_desc_valid", desc_valid, 1);
    chk("t6_desc_hdr", desc_hdr, 0);
    chk("t6_busy", busy, 0);
    idle(3);
    chk("t6_nchunk", chunkq.size(), 0);
    chunk_ready = 1'b0;
    blk(8'h0b, 56'd3);
    blk(8'h1b, 56'h41);
    blk(8'h1b, 56'h42);
    blk(8'h1b, 56'h600);
    chk("t6_pre_valid", chunk_valid, 1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("t6_rst_valid", chunk_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_data", chunk_data, 0);
    chk("t6_rst_last", chunk_last, 0);
    chk("t6_rst_hdr", desc_hdr, 0);
    chk("t6_rst_addr", desc_addr, 0);
    chk("t6_rst_err", err_valid, 0);
    idle(2);
    chk("t6_post_valid", chunk_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
